// File: rtl/rom_image_pkg.sv
// Shared types and constants for the image ROM reader.
// Optional build macro ROM_OREG_EN: ROM output register enabled, read latency 2 instead of 1.
package rom_image_pkg;

  localparam int unsigned PIX_W = 24;
  localparam logic [PIX_W-1:0] BG_COLOR_DEF = 24'h000000;

  // Width of the column/line counters.
  localparam int unsigned CNT_W = 16;

`ifdef ROM_OREG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  // Timing bundle carried alongside the ROM read.
  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
    logic win;
  } timing_t;

endpackage

// File: rtl/video_delay_pipe.sv
// Fixed-depth shift register with asynchronous active-low reset to zero.
module video_delay_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned TOT_W = DEPTH * WIDTH;

  // Newest entry at the bottom; the oldest falls off the top.
  logic [TOT_W-1:0] stage_q;

  // Shift one entry per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= TOT_W'({stage_q, data_i});
    end
  end

  assign data_o = stage_q[TOT_W-1 -: WIDTH];

endmodule

// File: rtl/rom_image_reader.sv
// Image ROM read initiator: places an IMG_W x IMG_H image inside the active video area,
// generates ROM addresses and re-times vs/hs/de to the returned pixel data.
// Optional build macro ROM_OREG_EN selects a 2-cycle ROM latency (total latency 3).
module rom_image_reader
  import rom_image_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = PIX_W,
  parameter int unsigned           IMG_W      = 256,
  parameter int unsigned           IMG_H      = 256,
  parameter int unsigned           IMG_X0     = 0,
  parameter int unsigned           IMG_Y0     = 0,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR   = BG_COLOR_DEF,
  parameter bit                    VS_POL     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vs_in,
  input  logic                  hs_in,
  input  logic                  de_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  vs_out,
  output logic                  hs_out,
  output logic                  de_out,
  output logic [DATA_WIDTH-1:0] rgb_out
);

  localparam int unsigned CMP_W = CNT_W + 1;
  localparam logic [CMP_W-1:0] X_LO = CMP_W'(IMG_X0);
  localparam logic [CMP_W-1:0] Y_LO = CMP_W'(IMG_Y0);
  localparam logic [CMP_W-1:0] W_CMP = CMP_W'(IMG_W);
  localparam logic [CMP_W-1:0] H_CMP = CMP_W'(IMG_H);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (64'(IMG_W) * 64'(IMG_H) > (64'd1 << ADDR_WIDTH)) begin : g_size_chk
    $error("rom_image_reader: IMG_W*IMG_H exceeds the ROM address space");
  end

  logic [CNT_W-1:0]      x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d, line_base_q, line_base_d;
  logic                  de_q, vs_act_q;
  logic                  vs_act, vs_edge, de_fall, x_in, y_in, in_win;
  logic [CMP_W-1:0]      x_off, y_off;

  assign vs_act  = (vs_in == VS_POL);
  assign vs_edge = vs_act & ~vs_act_q;
  assign de_fall = de_q & ~de_in;

  // Offset-then-compare: a counter below the origin wraps to a huge offset and fails the
  // upper bound, giving lo <= cnt < lo+size in one unsigned compare.
  assign x_off  = {1'b0, x_cnt_q} - X_LO;
  assign y_off  = {1'b0, y_cnt_q} - Y_LO;
  assign x_in   = (x_off < W_CMP);
  assign y_in   = (y_off < H_CMP);
  assign in_win = de_in & x_in & y_in;

  // Counter next-state; vsync edge wins over a coincident de falling edge.
  always_comb begin
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    addr_cnt_d  = addr_cnt_q;
    line_base_d = line_base_q;
    if (vs_edge) begin
      x_cnt_d     = '0;
      y_cnt_d     = '0;
      addr_cnt_d  = '0;
      line_base_d = '0;
    end else if (de_fall) begin
      x_cnt_d = '0;
      y_cnt_d = y_cnt_q + CNT_ONE;
      // Jump to the next image row even if this line was clipped horizontally.
      if (y_in) begin
        line_base_d = line_base_q + LINE_STEP;
        addr_cnt_d  = line_base_d;
      end
    end else if (de_in) begin
      x_cnt_d = x_cnt_q + CNT_ONE;
      if (in_win) begin
        addr_cnt_d = addr_cnt_q + ADDR_ONE;
      end
    end
  end

  // Counter and edge-detect state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      addr_cnt_q  <= '0;
      line_base_q <= '0;
      de_q        <= 1'b0;
      vs_act_q    <= 1'b0;
    end else begin
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      addr_cnt_q  <= addr_cnt_d;
      line_base_q <= line_base_d;
      de_q        <= de_in;
      vs_act_q    <= vs_act;
    end
  end

  assign rom_addr = addr_cnt_q;

  timing_t tin, tlat;
  assign tin = '{vs: vs_in, hs: hs_in, de: de_in, win: in_win};

  video_delay_pipe #(
    .DEPTH(LAT),
    .WIDTH($bits(timing_t))
  ) u_lat_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .data_i(tin),
    .data_o(tlat)
  );

  logic [DATA_WIDTH-1:0] rgb_next;
  logic [DATA_WIDTH+2:0] oreg_in, oreg_out;

  // Pixel select at the ROM data stage: image, background, or blank.
  always_comb begin
    rgb_next = '0;
    if (tlat.win) begin
      rgb_next = rom_data;
    end else if (tlat.de) begin
      rgb_next = BG_COLOR;
    end
  end

  assign oreg_in = {tlat.vs, tlat.hs, tlat.de, rgb_next};

  video_delay_pipe #(
    .DEPTH(1),
    .WIDTH(DATA_WIDTH + 3)
  ) u_out_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .data_i(oreg_in),
    .data_o(oreg_out)
  );

  assign {vs_out, hs_out, de_out, rgb_out} = oreg_out;

endmodule
